draw_triangle_stream: RTL and testbench
=======================================

Name: draw_triangle_stream

Overview:
Parametrised successor to the fixed 8-bit triangle outline drawer. Generates the rasterised outline of a triangle, or a single line, using integer Bresenham stepping. Pixels are emitted one per handshake on a valid/ready stream toward the framebuffer writer. Adds a start/busy/done control handshake, output backpressure, a clock enable, a line mode and correct signed error arithmetic at any coordinate width.

Parameters:
COORD_W, 8, width of each unsigned X/Y coordinate.

Ports:
ACLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous active-high reset
EN  in  1  clock enable; when 0 all state and outputs hold
START  in  1  request to draw; sampled only in IDLE
MODE  in  1  0 = line P0->P1 inclusive; 1 = closed triangle P0->P1->P2->P0
X_0, Y_0, X_1, Y_1, X_2, Y_2  in  COORD_W each  vertices, latched on START acceptance
X_OUT  out  COORD_W  pixel X
Y_OUT  out  COORD_W  pixel Y
PIX_VALID  out  1  pixel on X_OUT/Y_OUT is valid
PIX_READY  in  1  consumer accepts the pixel; transfer = PIX_VALID & PIX_READY
BUSY  out  1  high from START acceptance until the DONE cycle, inclusive
DONE  out  1  one-cycle pulse when drawing completes

Behaviour:
- Reset values: X_OUT=0, Y_OUT=0, PIX_VALID=0, BUSY=0, DONE=0; FSM in IDLE. RST has priority over EN.
- EN=0 freezes the FSM, registers and outputs. EN=1 is assumed in all cycles named below.
- FSM states: IDLE, SETUP, DRAW, FIN.
- IDLE: on START=1, latch vertices and MODE, set BUSY=1, select edge 0 (P0->P1), go to SETUP. START while BUSY=1 is ignored.
- SETUP (one cycle, no pixel output):
  - dx = |xe-xs|, dy = -|ye-ys|, sx/sy = +1 or -1 (toward end; +1 when the delta is 0), err = dx+dy.
  - dx, dy and err are signed COORD_W+2 bits.
  - Cur = start point. Go to DRAW with PIX_VALID=1.
- DRAW:
  - X_OUT/Y_OUT = Cur. Outputs are held stable while PIX_VALID=1 and PIX_READY=0.
  - Last pixel of the edge: in line mode, Cur == end point. In triangle mode, the next step would reach the end point, so the end vertex is not emitted because the next edge emits it.
  - On a transfer that is not the last pixel: e2 = 2*err; if e2 >= dy then err += dy, x += sx; if e2 <= dx then err += dx, y += sy; stay in DRAW (one pixel per clock when READY is held high).
  - On a transfer of the last pixel: PIX_VALID=0. If more edges remain (triangle mode, edge 0 or 1), advance the edge (P1->P2, then P2->P0) and go to SETUP. Otherwise go to FIN.
- Zero-length edges in triangle mode: SETUP skips them and goes to the next edge or to FIN; they emit no pixel.
- All three vertices equal in triangle mode: emit P0 exactly once.
- FIN: DONE=1 and BUSY=1 for one cycle, then IDLE with BUSY=0. A new START is accepted in the cycle after FIN.
- Latency, with READY=1: START accepted in cycle T, first pixel valid in T+2. Each edge change costs exactly one SETUP cycle.
- Pixel counts:
  - Line mode: max(|dx|,|dy|)+1 pixels.
  - Triangle mode: sum of max(|dx|,|dy|) over the three edges.
- Coordinates never wrap: steps stay in the [min,max] range of each edge, including full-scale edges (0 to 2^COORD_W-1).
- RST mid-draw: immediately returns to the reset values. No DONE pulse; the partial stream is abandoned.
- Vertex inputs may change after START acceptance without affecting the draw in progress.

Test Plan:
- Line, MODE=0, (0,0)->(3,1), READY=1 -> pixels (0,0),(1,0),(2,1),(3,1) valid in T+2..T+5; DONE in T+6; BUSY low in T+7.
- Triangle, MODE=1, (0,0),(2,0),(0,2), READY=1 -> (0,0),(1,0) in T+2..T+3; SETUP; (2,0),(1,1) in T+5..T+6; SETUP; (0,2),(0,1) in T+8..T+9; DONE in T+10.
- Backpressure: same triangle with PIX_READY toggled 1,0,0,1,... -> identical 6-pixel sequence; X_OUT/Y_OUT constant while READY=0; no pixel duplicated or dropped.
- Full-scale line, COORD_W=8, (255,0)->(0,255) -> 256 pixels (255-k,k); last pixel (0,255); no wrap.
- Degenerate triangle, all vertices (7,9) -> single pixel (7,9), then DONE. Triangle (1,1),(1,1),(4,1) -> (1,1),(2,1),(3,1),(4,1),(3,1),(2,1), then DONE.
- Control: START while BUSY is ignored. EN=0 for 3 cycles mid-edge freezes all outputs and state. RST asserted during a triangle draw -> next cycle PIX_VALID=0, BUSY=0, DONE never pulses; a later START redraws correctly.

Source files
------------

// File: rtl/draw_triangle_stream.sv
// rtl/draw_triangle_stream.sv - Bresenham line/triangle outline drawer with a valid/ready pixel stream
// Vertices are latched on START; each edge gets one SETUP cycle, then one pixel per accepted handshake.
module draw_triangle_stream #(
   parameter int COORD_W = 8
) (
   input  logic               ACLK,
   input  logic               RST,
   input  logic               EN,
   input  logic               START,
   input  logic               MODE,
   input  logic [COORD_W-1:0] X_0,
   input  logic [COORD_W-1:0] Y_0,
   input  logic [COORD_W-1:0] X_1,
   input  logic [COORD_W-1:0] Y_1,
   input  logic [COORD_W-1:0] X_2,
   input  logic [COORD_W-1:0] Y_2,
   output logic [COORD_W-1:0] X_OUT,
   output logic [COORD_W-1:0] Y_OUT,
   output logic               PIX_VALID,
   input  logic               PIX_READY,
   output logic               BUSY,
   output logic               DONE
);

   localparam int EW = COORD_W + 2;

   typedef enum logic [1:0] {IDLE, SETUP, DRAW, FIN} state_t;

   state_t state, state_nxt;

   logic [COORD_W-1:0] vx0, vy0, vx1, vy1, vx2, vy2;
   logic               mode_r;
   logic [1:0]         edge_sel;
   logic [COORD_W-1:0] end_x, end_y;
   logic signed [EW-1:0] dx, dy, err;
   logic               sx, sy;
   logic               single;

   logic [COORD_W-1:0] xs, ys, xe, ye;
   logic [COORD_W-1:0] ux, uy;
   logic signed [EW-1:0] dx_s, dy_s, err_s;
   logic               zero_len, all_same, skip_edge;

   logic signed [EW:0]   e2, dx_w, dy_w;
   logic                 step_x, step_y;
   logic [COORD_W-1:0]   nx, ny;
   logic signed [EW-1:0] err_nxt;
   logic                 at_end, next_end, last_pix, xfer;

   // Edge endpoints from the latched vertices: 0 = P0->P1, 1 = P1->P2, 2 = P2->P0
   always_comb begin
      xs = vx2; ys = vy2; xe = vx0; ye = vy0;
      case (edge_sel)
         2'd0: begin xs = vx0; ys = vy0; xe = vx1; ye = vy1; end
         2'd1: begin xs = vx1; ys = vy1; xe = vx2; ye = vy2; end
         default: ;
      endcase
   end

   always_comb begin
      ux        = (xe >= xs) ? xe - xs : xs - xe;
      uy        = (ye >= ys) ? ye - ys : ys - ye;
      dx_s      = $signed({2'b00, ux});
      dy_s      = -$signed({2'b00, uy});
      err_s     = dx_s + dy_s;
      zero_len  = (xs == xe) && (ys == ye);
      all_same  = (vx0 == vx1) && (vx1 == vx2) && (vy0 == vy1) && (vy1 == vy2);
      // An all-equal triangle is drawn as its single vertex rather than skipped entirely
      skip_edge = mode_r && zero_len && !all_same;
   end

   always_comb begin
      e2       = {err, 1'b0};
      dx_w     = dx;
      dy_w     = dy;
      step_x   = (e2 >= dy_w);
      step_y   = (e2 <= dx_w);
      nx       = step_x ? (sx ? X_OUT + COORD_W'(1) : X_OUT - COORD_W'(1)) : X_OUT;
      ny       = step_y ? (sy ? Y_OUT + COORD_W'(1) : Y_OUT - COORD_W'(1)) : Y_OUT;
      err_nxt  = err + (step_x ? dy : '0) + (step_y ? dx : '0);
      at_end   = (X_OUT == end_x) && (Y_OUT == end_y);
      next_end = (nx == end_x) && (ny == end_y);
      // Triangle edges stop one short; the following edge emits the shared vertex
      last_pix = mode_r ? (single || next_end) : at_end;
      xfer     = PIX_VALID && PIX_READY;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (START) state_nxt = SETUP;
         SETUP: begin
            if (!skip_edge)            state_nxt = DRAW;
            else if (edge_sel == 2'd2) state_nxt = FIN;
         end
         DRAW: begin
            if (xfer && last_pix)
               state_nxt = (mode_r && !single && edge_sel != 2'd2) ? SETUP : FIN;
         end
         FIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (RST) begin
         state     <= IDLE;
         X_OUT     <= '0;
         Y_OUT     <= '0;
         PIX_VALID <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         vx0 <= '0; vy0 <= '0; vx1 <= '0; vy1 <= '0; vx2 <= '0; vy2 <= '0;
         mode_r    <= 1'b0;
         edge_sel  <= 2'd0;
         end_x     <= '0;
         end_y     <= '0;
         dx        <= '0;
         dy        <= '0;
         err       <= '0;
         sx        <= 1'b1;
         sy        <= 1'b1;
         single    <= 1'b0;
      end else if (EN) begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (START) begin
                  vx0 <= X_0; vy0 <= Y_0; vx1 <= X_1; vy1 <= Y_1; vx2 <= X_2; vy2 <= Y_2;
                  mode_r   <= MODE;
                  edge_sel <= 2'd0;
                  BUSY     <= 1'b1;
               end
            end
            SETUP: begin
               if (skip_edge) begin
                  if (edge_sel == 2'd2) DONE <= 1'b1;
                  else                  edge_sel <= edge_sel + 2'd1;
               end else begin
                  X_OUT     <= xs;
                  Y_OUT     <= ys;
                  end_x     <= xe;
                  end_y     <= ye;
                  dx        <= dx_s;
                  dy        <= dy_s;
                  err       <= err_s;
                  sx        <= (xe >= xs);
                  sy        <= (ye >= ys);
                  single    <= mode_r && all_same;
                  PIX_VALID <= 1'b1;
               end
            end
            DRAW: begin
               if (xfer) begin
                  if (last_pix) begin
                     PIX_VALID <= 1'b0;
                     if (state_nxt == FIN) DONE <= 1'b1;
                     else                  edge_sel <= edge_sel + 2'd1;
                  end else begin
                     X_OUT <= nx;
                     Y_OUT <= ny;
                     err   <= err_nxt;
                  end
               end
            end
            FIN: begin
               DONE <= 1'b0;
               BUSY <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_draw_triangle_stream.sv
// tb/tb_draw_triangle_stream.sv - scoreboard bench for draw_triangle_stream
// Expected pixels are queued per draw; a negedge monitor checks the head while valid and pops on transfer.
module tb_draw_triangle_stream;

   localparam int W = 8;

   logic         ACLK = 1'b0;
   logic         RST, EN, START, MODE, PIX_READY;
   logic [W-1:0] X_0, Y_0, X_1, Y_1, X_2, Y_2;
   logic [W-1:0] X_OUT, Y_OUT;
   logic         PIX_VALID, BUSY, DONE;

   int           total = 0;
   int           bad   = 0;
   int           cyc   = 0;
   logic [15:0]  sb[$];
   bit           bp_en = 1'b0;
   int           t, td;

   draw_triangle_stream #(.COORD_W(W)) dut (
      .ACLK(ACLK), .RST(RST), .EN(EN), .START(START), .MODE(MODE),
      .X_0(X_0), .Y_0(Y_0), .X_1(X_1), .Y_1(Y_1), .X_2(X_2), .Y_2(Y_2),
      .X_OUT(X_OUT), .Y_OUT(Y_OUT), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
      .BUSY(BUSY), .DONE(DONE)
   );

   always #5 ACLK = ~ACLK;

   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
      sb.push_back({x, y});
   endtask

   task automatic push_tri_a();
      push(0, 0); push(1, 0); push(2, 0); push(1, 1); push(0, 2); push(0, 1);
   endtask

   task automatic start_draw(input logic m, input logic [W-1:0] x0, input logic [W-1:0] y0,
                             input logic [W-1:0] x1, input logic [W-1:0] y1,
                             input logic [W-1:0] x2, input logic [W-1:0] y2, output int ts);
      MODE = m; X_0 = x0; Y_0 = y0; X_1 = x1; Y_1 = y1; X_2 = x2; Y_2 = y2;
      START = 1'b1;
      ts = cyc;
      tick();
      START = 1'b0;
      MODE = ~m;
      X_0 = W'($urandom); Y_0 = W'($urandom); X_1 = W'($urandom);
      Y_1 = W'($urandom); X_2 = W'($urandom); Y_2 = W'($urandom);
   endtask

   task automatic wait_done(output int tdone);
      int n = 0;
      tdone = -1;
      while (n < 1000) begin
         @(negedge ACLK);
         if (DONE === 1'b1) begin
            tdone = cyc;
            break;
         end
         n++;
      end
      if (tdone < 0) chk("done_timeout", 0, 1);
      else           chk("busy_at_done", BUSY, 1);
      chk("leftover_px", sb.size(), 0);
   endtask

   // Ready driver: held high, or the 1,0,0,1 pattern while backpressure is enabled
   initial begin
      int i = 0;
      PIX_READY = 1'b1;
      forever begin
         @(posedge ACLK);
         #2;
         if (bp_en) begin
            PIX_READY = (i == 0 || i == 3);
            i = (i + 1) % 4;
         end else begin
            PIX_READY = 1'b1;
            i = 0;
         end
      end
   end

   always @(negedge ACLK) begin
      if (!RST && PIX_VALID) begin
         if (sb.size() == 0) chk("extra_px", 1, 0);
         else begin
            chk("px_x", X_OUT, sb[0][15:8]);
            chk("px_y", Y_OUT, sb[0][7:0]);
            if (PIX_READY && EN) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      RST = 1'b1; EN = 1'b1; START = 1'b0; MODE = 1'b0;
      X_0 = '0; Y_0 = '0; X_1 = '0; Y_1 = '0; X_2 = '0; Y_2 = '0;
      repeat (3) tick();
      @(negedge ACLK);
      chk("rst_x", X_OUT, 0);
      chk("rst_y", Y_OUT, 0);
      chk("rst_valid", PIX_VALID, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      tick();
      RST = 1'b0;
      tick();

      // Line (0,0)->(3,1)
      push(0, 0); push(1, 0); push(2, 1); push(3, 1);
      start_draw(1'b0, 0, 0, 3, 1, 0, 0, t);
      @(negedge ACLK);
      chk("line_setup_valid", PIX_VALID, 0);
      chk("line_setup_busy", BUSY, 1);
      wait_done(td);
      chk("line_done_cyc", td, t + 6);
      tick();
      @(negedge ACLK);
      chk("line_busy_low", BUSY, 0);
      tick();

      // Triangle with a START pulse mid-draw that must be ignored
      push_tri_a();
      start_draw(1'b1, 0, 0, 2, 0, 0, 2, t);
      tick(); tick();
      START = 1'b1; MODE = 1'b0; X_0 = 9; Y_0 = 9;
      tick();
      START = 1'b0;
      wait_done(td);
      chk("tri_done_cyc", td, t + 10);
      tick(); tick();
      @(negedge ACLK);
      chk("tri_no_restart_busy", BUSY, 0);
      chk("tri_no_restart_valid", PIX_VALID, 0);
      tick();

      // Same triangle under backpressure
      bp_en = 1'b1;
      push_tri_a();
      start_draw(1'b1, 0, 0, 2, 0, 0, 2, t);
      wait_done(td);
      bp_en = 1'b0;
      tick(); tick();

      // Steep line (5,2)->(3,7) with a 3-cycle EN freeze mid-edge
      push(5, 2); push(5, 3); push(4, 4); push(4, 5); push(3, 6); push(3, 7);
      start_draw(1'b0, 5, 2, 3, 7, 0, 0, t);
      tick(); tick();
      EN = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge ACLK);
         chk("freeze_valid", PIX_VALID, 1);
         chk("freeze_busy", BUSY, 1);
         tick();
      end
      EN = 1'b1;
      wait_done(td);
      chk("steep_done_cyc", td, t + 11);
      tick(); tick();

      // Full-scale anti-diagonal
      for (int k = 0; k < 256; k++) push(W'(255 - k), W'(k));
      start_draw(1'b0, 255, 0, 0, 255, 0, 0, t);
      wait_done(td);
      chk("full_done_cyc", td, t + 258);
      tick(); tick();

      // Degenerate triangles
      push(7, 9);
      start_draw(1'b1, 7, 9, 7, 9, 7, 9, t);
      wait_done(td);
      chk("point_done_cyc", td, t + 3);
      tick(); tick();
      push(1, 1); push(2, 1); push(3, 1); push(4, 1); push(3, 1); push(2, 1);
      start_draw(1'b1, 1, 1, 1, 1, 4, 1, t);
      wait_done(td);
      chk("flat_done_cyc", td, t + 10);
      tick(); tick();

      // Reset mid-draw, then redraw
      push_tri_a();
      start_draw(1'b1, 0, 0, 2, 0, 0, 2, t);
      tick(); tick(); tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      @(negedge ACLK);
      chk("midrst_valid", PIX_VALID, 0);
      chk("midrst_busy", BUSY, 0);
      chk("midrst_done", DONE, 0);
      sb.delete();
      for (int k = 0; k < 5; k++) begin
         @(negedge ACLK);
         chk("midrst_no_done", DONE, 0);
      end
      tick();
      push_tri_a();
      start_draw(1'b1, 0, 0, 2, 0, 0, 2, t);
      wait_done(td);
      chk("redraw_done_cyc", td, t + 10);
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
